// File: rtl/data_mem_pkg.sv
// Shared constants and enums for the data memory responder: MMIO page,
// register offsets, region decode and run/halt state.
package data_mem_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFFFF;
    localparam logic [15:0] HALT_OFS  = 16'h0000;
    localparam logic [15:0] CYCLE_OFS = 16'h0004;
    localparam logic [15:0] WRCNT_OFS = 16'h0008;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_MMIO,
        RGN_NONE
    } region_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/data_mem_mmio.sv
// MMIO register file (HALT, WRCNT, optional CYCLE) and the run/halt FSM.
// CYCLE register exists only when DATA_MEM_CYCLE_CNT_EN is defined.
module data_mem_mmio
    import data_mem_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     ram_wr,
    input  logic [15:0]              ofs,
    input  logic [WORD_BITWIDTH-1:0] wdata,
    output logic [WORD_BITWIDTH-1:0] rdata,
    output logic                     halt,
    output logic [WORD_BITWIDTH-1:0] halt_code
);

    state_e                   state_q, state_d;
    logic [WORD_BITWIDTH-1:0] wrcnt;
    logic                     running;

    assign running = (state_q == ST_RUN);
    assign halt    = (state_q == ST_HALTED);

    always_comb begin
        state_d = state_q;
        if (running && wr_en && ofs == HALT_OFS)
            state_d = ST_HALTED;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            halt_code <= '0;
            wrcnt     <= '0;
        end else begin
            state_q <= state_d;
            // Once halted, the code and write count stay frozen
            if (running) begin
                if (wr_en && ofs == HALT_OFS)
                    halt_code <= wdata;
                if (ram_wr)
                    wrcnt <= wrcnt + WORD_BITWIDTH'(1);
            end
        end
    end

`ifdef DATA_MEM_CYCLE_CNT_EN
    logic [WORD_BITWIDTH-1:0] cycle_cnt;

    // A write loads the counter directly; the increment resumes next cycle
    always_ff @(posedge clk) begin
        if (!rst)
            cycle_cnt <= '0;
        else if (running) begin
            if (wr_en && ofs == CYCLE_OFS)
                cycle_cnt <= wdata;
            else
                cycle_cnt <= cycle_cnt + WORD_BITWIDTH'(1);
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            HALT_OFS:  rdata = {{(WORD_BITWIDTH-1){1'b0}}, halt};
            WRCNT_OFS: rdata = wrcnt;
`ifdef DATA_MEM_CYCLE_CNT_EN
            CYCLE_OFS: rdata = cycle_cnt;
`endif
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Core data-memory responder: word RAM, address decode, sticky error flag.
// Define DATA_MEM_CYCLE_CNT_EN to map the CYCLE counter at 0xFFFF0004.
module data_mem_resp
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS   = 1024,
    parameter int WORD_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_ce_i,
    input  logic                     data_we_i,
    input  logic [WORD_BITWIDTH-1:0] data_addr_i,
    input  logic [WORD_BITWIDTH-1:0] data_wdata_i,
    output logic [WORD_BITWIDTH-1:0] data_rdata_o,
    output logic                     halt_o,
    output logic [WORD_BITWIDTH-1:0] halt_code_o,
    output logic                     err_o
);

    localparam int                       AW        = $clog2(DEPTH_WORDS);
    localparam logic [WORD_BITWIDTH-1:0] RAM_BYTES = WORD_BITWIDTH'(DEPTH_WORDS * 4);

    logic [WORD_BITWIDTH-1:0] mem [DEPTH_WORDS];
    logic [WORD_BITWIDTH-1:0] mmio_rdata;
    logic [AW-1:0]            idx;
    logic [15:0]              ofs;
    region_e                  rgn;
    logic                     mmio_reg, legal, ram_wr, mmio_wr;

    assign idx = data_addr_i[AW+1:2];
    assign ofs = data_addr_i[15:0];

    always_comb begin
        rgn = RGN_NONE;
        if (data_addr_i < RAM_BYTES)
            rgn = RGN_RAM;
        else if (data_addr_i[WORD_BITWIDTH-1 -: 16] == MMIO_BASE)
            rgn = RGN_MMIO;
    end

    // Only implemented registers are legal; holes in the MMIO page count as unmapped
    always_comb begin
        mmio_reg = (ofs == HALT_OFS) || (ofs == WRCNT_OFS);
`ifdef DATA_MEM_CYCLE_CNT_EN
        if (ofs == CYCLE_OFS)
            mmio_reg = 1'b1;
`endif
    end

    assign legal   = (data_addr_i[1:0] == 2'b00) &&
                     ((rgn == RGN_RAM) || (rgn == RGN_MMIO && mmio_reg));
    assign ram_wr  = rst && data_we_i && legal && (rgn == RGN_RAM) && !halt_o;
    assign mmio_wr = data_we_i && legal && (rgn == RGN_MMIO);

    always_ff @(posedge clk) begin
        if (ram_wr)
            mem[idx] <= data_wdata_i;
    end

    always_comb begin
        data_rdata_o = '0;
        if (data_ce_i && legal)
            data_rdata_o = (rgn == RGN_RAM) ? mem[idx] : mmio_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_o <= 1'b0;
        else if ((data_ce_i || data_we_i) && !legal)
            err_o <= 1'b1;
    end

    data_mem_mmio #(
        .WORD_BITWIDTH(WORD_BITWIDTH)
    ) u_mmio (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (mmio_wr),
        .ram_wr    (ram_wr),
        .ofs       (ofs),
        .wdata     (data_wdata_i),
        .rdata     (mmio_rdata),
        .halt      (halt_o),
        .halt_code (halt_code_o)
    );

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: vector table plus reset/halt/counter sequences.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, halt_code;
    logic        halt, err;
    logic [31:0] rd;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    data_mem_resp dut (
        .clk          (clk),
        .rst          (rst),
        .data_ce_i    (ce),
        .data_we_i    (we),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .halt_o       (halt),
        .halt_code_o  (halt_code),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: rd captures the combinational read before the edge
    task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = c; we = w; addr = a; wdata = d;
        #1 rd = rdata;
        @(posedge clk);
        #1 ce = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        //          ce    we    addr          wdata         exp_rd        exp_err
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_0001, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0018, 32'h0000_0007, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'hFFFF_0008, 32'h0,         32'h4,         1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_0001, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0,         32'h0,         1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0063, 32'h0,         1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'hFFFF_0008, 32'h0,         32'h4,         1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 32'h0,         1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h5A5A_5A5A, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};

        do_reset();
        check("reset_halt", {31'b0, halt}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_code", halt_code, 32'h0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
        end

        // Reset clears the flags and counters but leaves RAM intact
        do_reset();
        check("rst_err_clr", {31'b0, err}, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check("ram_kept", rd, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check("wrcnt_rst", rd, 32'h0);

        // Misaligned write with read: ignored, returns 0, sticky error
        step(1'b1, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF);
        check("misal_rdata", rd, 32'h0);
        check("misal_err", {31'b0, err}, 32'h1);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check("misal_ram", rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        check("misal_err_hold", {31'b0, err}, 32'h1);
        do_reset();
        check("misal_err_clr", {31'b0, err}, 32'h0);

        step(1'b0, 1'b1, 32'h0000_0020, 32'h1);
        step(1'b0, 1'b1, 32'h0000_0024, 32'h2);
        step(1'b0, 1'b1, 32'h0000_0028, 32'h3);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check("wrcnt_3", rd, 32'h3);

        step(1'b0, 1'b1, 32'hFFFF_0004, 32'd100);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
`ifdef DATA_MEM_CYCLE_CNT_EN
        check("cycle_rd", rd, 32'd101);
        check("cycle_err", {31'b0, err}, 32'h0);
`else
        check("cycle_rd", rd, 32'h0);
        check("cycle_err", {31'b0, err}, 32'h1);
`endif

        // Halt: later writes ignored, reads still serviced
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_0000, 32'h2A);
        check("halt_set", {31'b0, halt}, 32'h1);
        check("halt_code", halt_code, 32'h2A);
        step(1'b0, 1'b1, 32'h0000_0020, 32'h5);
        step(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        check("halt_wr_ign", rd, 32'h1);
        step(1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
        check("halt_rd", rd, 32'h1);
        step(1'b0, 1'b1, 32'hFFFF_0000, 32'h77);
        check("halt_code_keep", halt_code, 32'h2A);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check("halt_wrcnt", rd, 32'h0);
        check("halt_err", {31'b0, err}, 32'h0);

        // Write coinciding with a reset edge is suppressed
        do_reset();
        step(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b0; we = 1'b1; addr = 32'h0000_0040; wdata = 32'h0000_0BAD;
        @(posedge clk);
        #1 rst = 1'b1; we = 1'b0;
        check("rw_halt", {31'b0, halt}, 32'h0);
        check("rw_err", {31'b0, err}, 32'h0);
        check("rw_code", halt_code, 32'h0);
        step(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("rw_ram", rd, 32'h1234_5678);
        step(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        check("rw_wrcnt", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
